// File: rtl/ehgu_basic_pkg.sv
// Shared helpers for ehgu blocks: gray-code conversion, FIFO pointer type,
// and a power-of-two depth check.
package ehgu_basic_pkg;

    localparam int unsigned FIFO_AWIDTH = 4;

    typedef logic [FIFO_AWIDTH:0] fifo_ptr_t;

    function automatic logic [31:0] bin2gray(input logic [31:0] b);
        return b ^ (b >> 1);
    endfunction

    function automatic logic [31:0] gray2bin(input logic [31:0] g);
        logic [31:0] b;
        b = g;
        for (int unsigned i = 1; i < 32; i++) begin
            b = b ^ (g >> i);
        end
        return b;
    endfunction

    function automatic bit is_pow2(input int unsigned n);
        return (n != 0) && ((n & (n - 1)) == 0);
    endfunction

endpackage

// File: rtl/ehgu_fifo_ptr.sv
// FIFO pointer: binary counter with lap bit plus a registered gray copy
// that is safe to hand across a clock domain.
module ehgu_fifo_ptr
    import ehgu_basic_pkg::*;
#(
    parameter int unsigned AWIDTH = 4
) (
    input  logic            clk,
    input  logic            rstn,
    input  logic            inc,
    output logic [AWIDTH:0] ptr,
    output logic [AWIDTH:0] ptr_next,
    output logic [AWIDTH:0] gray
);

    assign ptr_next = ptr + (AWIDTH + 1)'(inc);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            ptr  <= '0;
            gray <= '0;
        end else begin
            ptr  <= ptr_next;
            gray <= (AWIDTH + 1)'(bin2gray(32'(ptr_next)));
        end
    end

endmodule

// File: rtl/ehgu_synqzx.sv
// Multi-stage flop synchroniser for a gray-coded bus; async active-low reset.
module ehgu_synqzx #(
    parameter int unsigned WIDTH  = 1,
    parameter int unsigned STAGES = 2
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] sync_q [STAGES];

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int unsigned i = 0; i < STAGES; i++) begin
                sync_q[i] <= '0;
            end
        end else begin
            sync_q[0] <= d;
            for (int unsigned i = 1; i < STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
        end
    end

    assign q = sync_q[STAGES-1];

endmodule

// File: rtl/ehgu_fifo_ctrl.sv
// Dual/single-clock FIFO controller driving an external dual-port RAM.
// Define EHGU_FIFO_CTRL_ERR_EN to build the sticky overflow/underflow flags.
module ehgu_fifo_ctrl
    import ehgu_basic_pkg::*;
#(
    parameter int unsigned SYNC_TYPE    = 0,
    parameter int unsigned SYNC_STG_W2R = 2,
    parameter int unsigned SYNC_STG_R2W = 2,
    parameter int unsigned AWIDTH       = 4,
    parameter int unsigned AFULL_THR    = 12,
    parameter int unsigned AEMPTY_THR   = 2
) (
    input  logic              wclk,
    input  logic              wrstn,
    input  logic              rclk,
    input  logic              rrstn,
    input  logic              wr_valid,
    output logic              wr_ready,
    output logic              wenable,
    output logic [AWIDTH-1:0] waddr,
    output logic              full,
    output logic              almost_full,
    output logic [AWIDTH:0]   wlevel,
    input  logic              rd_req,
    output logic              renable,
    output logic [AWIDTH-1:0] raddr,
    output logic              dout_valid,
    output logic              empty,
    output logic              almost_empty,
    output logic [AWIDTH:0]   rlevel,
    output logic              overflow,
    output logic              underflow
);

    localparam int unsigned DEPTH = 2 ** AWIDTH;

    typedef logic [AWIDTH:0] ptr_t;

    localparam ptr_t LAP_BIT   = ptr_t'(1) << AWIDTH;
    localparam ptr_t FULL_MASK = ptr_t'(3) << (AWIDTH - 1);

    if (!is_pow2(DEPTH) || AFULL_THR < 1 || AFULL_THR > DEPTH ||
        AEMPTY_THR > DEPTH - 1 || SYNC_STG_W2R < 2 || SYNC_STG_R2W < 2) begin : g_cfg_err
        $error("ehgu_fifo_ctrl: illegal parameter combination");
    end

    ptr_t wptr, wptr_next, wgray;
    ptr_t rptr, rptr_next, rgray;
    ptr_t wlevel_next, rlevel_next;
    logic full_next, empty_next;

    assign wr_ready = ~full;
    assign wenable  = wr_valid & ~full;
    assign renable  = rd_req & ~empty;
    assign waddr    = wptr[AWIDTH-1:0];
    assign raddr    = rptr[AWIDTH-1:0];

    ehgu_fifo_ptr #(.AWIDTH(AWIDTH)) u_wptr (
        .clk      (wclk),
        .rstn     (wrstn),
        .inc      (wenable),
        .ptr      (wptr),
        .ptr_next (wptr_next),
        .gray     (wgray)
    );

    ehgu_fifo_ptr #(.AWIDTH(AWIDTH)) u_rptr (
        .clk      (rclk),
        .rstn     (rrstn),
        .inc      (renable),
        .ptr      (rptr),
        .ptr_next (rptr_next),
        .gray     (rgray)
    );

    if (SYNC_TYPE == 0) begin : g_async
        ptr_t rsync, wsync;

        ehgu_synqzx #(.WIDTH(AWIDTH + 1), .STAGES(SYNC_STG_R2W)) u_sync_r2w (
            .clk  (wclk),
            .rstn (wrstn),
            .d    (rgray),
            .q    (rsync)
        );

        ehgu_synqzx #(.WIDTH(AWIDTH + 1), .STAGES(SYNC_STG_W2R)) u_sync_w2r (
            .clk  (rclk),
            .rstn (rrstn),
            .d    (wgray),
            .q    (wsync)
        );

        // Full in gray space: top two bits inverted means one lap ahead.
        assign full_next   = (ptr_t'(bin2gray(32'(wptr_next))) == (rsync ^ FULL_MASK));
        assign wlevel_next = wptr_next - ptr_t'(gray2bin(32'(rsync)));
        assign empty_next  = (ptr_t'(bin2gray(32'(rptr_next))) == wsync);
        assign rlevel_next = ptr_t'(gray2bin(32'(wsync))) - rptr_next;
    end else begin : g_sync
        // Same clock: use the other side's next pointer so flags track in one cycle.
        assign full_next   = (wptr_next == (rptr_next ^ LAP_BIT));
        assign wlevel_next = wptr_next - rptr_next;
        assign empty_next  = (rptr_next == wptr_next);
        assign rlevel_next = wptr_next - rptr_next;
    end

    always_ff @(posedge wclk or negedge wrstn) begin
        if (!wrstn) begin
            full        <= 1'b0;
            almost_full <= 1'b0;
            wlevel      <= '0;
        end else begin
            full        <= full_next;
            almost_full <= (32'(wlevel_next) >= AFULL_THR);
            wlevel      <= wlevel_next;
        end
    end

    always_ff @(posedge rclk or negedge rrstn) begin
        if (!rrstn) begin
            empty        <= 1'b1;
            almost_empty <= 1'b1;
            rlevel       <= '0;
            dout_valid   <= 1'b0;
        end else begin
            empty        <= empty_next;
            almost_empty <= (32'(rlevel_next) <= AEMPTY_THR);
            rlevel       <= rlevel_next;
            dout_valid   <= renable;
        end
    end

`ifdef EHGU_FIFO_CTRL_ERR_EN
    always_ff @(posedge wclk or negedge wrstn) begin
        if (!wrstn) begin
            overflow <= 1'b0;
        end else if (wr_valid && full) begin
            overflow <= 1'b1;
        end
    end

    always_ff @(posedge rclk or negedge rrstn) begin
        if (!rrstn) begin
            underflow <= 1'b0;
        end else if (rd_req && empty) begin
            underflow <= 1'b1;
        end
    end
`else
    assign overflow  = 1'b0;
    assign underflow = 1'b0;
`endif

endmodule

// File: tb/tb_ehgu_fifo_ctrl.sv
// Directed bench for ehgu_fifo_ctrl: async instance with a RAM model, plus a
// single-clock instance for the simultaneous read/write-at-full case.
`timescale 1ns/1ps
module tb_ehgu_fifo_ctrl;

`ifdef EHGU_FIFO_CTRL_ERR_EN
    localparam logic ERR_EXP = 1'b1;
`else
    localparam logic ERR_EXP = 1'b0;
`endif

    int unsigned whalf = 5;
    int unsigned rhalf = 5;
    logic wclk, rclk;

    initial begin
        wclk = 1'b0;
        forever #(whalf) wclk = ~wclk;
    end

    initial begin
        rclk = 1'b0;
        #2;
        forever #(rhalf) rclk = ~rclk;
    end

    logic       wrstn, rrstn, wr_valid, rd_req;
    logic       wr_ready, wenable, full, almost_full;
    logic       renable, dout_valid, empty, almost_empty, overflow, underflow;
    logic [3:0] waddr, raddr;
    logic [4:0] wlevel, rlevel;

    logic       s_wrstn, s_rrstn, s_wr_valid, s_rd_req;
    logic       s_wr_ready, s_wenable, s_full, s_almost_full;
    logic       s_renable, s_dout_valid, s_empty, s_almost_empty, s_overflow, s_underflow;
    logic [3:0] s_waddr, s_raddr;
    logic [4:0] s_wlevel, s_rlevel;

    ehgu_fifo_ctrl #(.SYNC_TYPE(0), .AWIDTH(4)) u_dut (
        .wclk(wclk), .wrstn(wrstn), .rclk(rclk), .rrstn(rrstn),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wenable(wenable), .waddr(waddr),
        .full(full), .almost_full(almost_full), .wlevel(wlevel),
        .rd_req(rd_req), .renable(renable), .raddr(raddr), .dout_valid(dout_valid),
        .empty(empty), .almost_empty(almost_empty), .rlevel(rlevel),
        .overflow(overflow), .underflow(underflow)
    );

    ehgu_fifo_ctrl #(.SYNC_TYPE(1), .AWIDTH(4)) u_dut_s (
        .wclk(wclk), .wrstn(s_wrstn), .rclk(wclk), .rrstn(s_rrstn),
        .wr_valid(s_wr_valid), .wr_ready(s_wr_ready), .wenable(s_wenable), .waddr(s_waddr),
        .full(s_full), .almost_full(s_almost_full), .wlevel(s_wlevel),
        .rd_req(s_rd_req), .renable(s_renable), .raddr(s_raddr), .dout_valid(s_dout_valid),
        .empty(s_empty), .almost_empty(s_almost_empty), .rlevel(s_rlevel),
        .overflow(s_overflow), .underflow(s_underflow)
    );

    logic [7:0] mem [16];
    logic [7:0] wdata, rdata;

    always @(posedge wclk) if (wenable) mem[waddr] <= wdata;
    always @(posedge rclk) if (renable) rdata <= mem[raddr];

    int unsigned both_viol = 0;
    always @(negedge wclk) if (wrstn && rrstn && full && empty) both_viol++;

    int unsigned n_vec = 0;
    int unsigned n_err = 0;
    int unsigned mw = 0;
    int unsigned mr = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic wtick();
        @(posedge wclk);
        #1;
    endtask

    task automatic rtick();
        @(posedge rclk);
        #1;
    endtask

    task automatic stream(input int unsigned wh, input int unsigned rh, input int unsigned n);
        int unsigned sent, got, dq;
        whalf = wh;
        rhalf = rh;
        repeat (3) wtick();
        sent = 0;
        got  = 0;
        dq   = mr;
        fork
            begin
                for (int c = 0; c < 3000 && sent < n; c++) begin
                    if ($urandom_range(0, 3) != 0) begin
                        wr_valid = 1'b1;
                        wdata    = 8'(mw);
                    end else begin
                        wr_valid = 1'b0;
                    end
                    #1;
                    if (wenable) begin
                        mw++;
                        sent++;
                    end
                    wtick();
                end
                wr_valid = 1'b0;
            end
            begin
                rtick();
                for (int c = 0; c < 5000 && got < n; c++) begin
                    rd_req = ($urandom_range(0, 3) != 0);
                    #1;
                    if (renable) mr++;
                    rtick();
                    if (dout_valid) begin
                        check_val("stream_data", 32'(rdata), 32'(8'(dq)));
                        dq++;
                        got++;
                    end
                end
                rd_req = 1'b0;
            end
        join
        check_val("stream_sent", sent, n);
        check_val("stream_got", got, n);
        repeat (4) rtick();
        repeat (4) wtick();
        check_val("stream_waddr", 32'(waddr), mw % 16);
        check_val("stream_raddr", 32'(raddr), mr % 16);
        check_val("stream_empty", 32'(empty), 1);
        check_val("stream_full", 32'(full), 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int lat;
        wr_valid = 1'b0; rd_req = 1'b0; wdata = '0;
        s_wr_valid = 1'b0; s_rd_req = 1'b0;
        wrstn = 1'b0; rrstn = 1'b0; s_wrstn = 1'b0; s_rrstn = 1'b0;
        repeat (3) wtick();

        check_val("rst_full", 32'(full), 0);
        check_val("rst_wr_ready", 32'(wr_ready), 1);
        check_val("rst_wlevel", 32'(wlevel), 0);
        check_val("rst_afull", 32'(almost_full), 0);
        check_val("rst_empty", 32'(empty), 1);
        check_val("rst_rlevel", 32'(rlevel), 0);
        check_val("rst_aempty", 32'(almost_empty), 1);
        check_val("rst_dout_valid", 32'(dout_valid), 0);
        check_val("rst_waddr", 32'(waddr), 0);
        check_val("rst_raddr", 32'(raddr), 0);
        check_val("rst_overflow", 32'(overflow), 0);
        check_val("rst_underflow", 32'(underflow), 0);
        check_val("rst_s_full", 32'(s_full), 0);
        check_val("rst_s_empty", 32'(s_empty), 1);

        wrstn = 1'b1; rrstn = 1'b1; s_wrstn = 1'b1; s_rrstn = 1'b1;
        repeat (2) wtick();

        // write-to-visible latency, rclk edge 2ns after wclk edge
        wr_valid = 1'b1;
        wdata    = 8'(mw);
        wtick();
        wr_valid = 1'b0;
        mw++;
        lat = 0;
        for (int k = 1; k <= 10; k++) begin
            rtick();
            if (!empty) begin
                lat = k;
                break;
            end
        end
        check_val("empty_fall_latency", lat, 3);
        check_val("rlevel_one", 32'(rlevel), 1);
        rd_req = 1'b1;
        #1;
        check_val("single_renable", 32'(renable), 1);
        rtick();
        rd_req = 1'b0;
        mr++;
        check_val("single_dout_valid", 32'(dout_valid), 1);
        check_val("single_rdata", 32'(rdata), 0);
        check_val("single_empty", 32'(empty), 1);

        // read while empty
        rd_req = 1'b1;
        for (int k = 0; k < 5; k++) begin
            #1;
            check_val("empty_rd_renable", 32'(renable), 0);
            check_val("empty_rd_raddr", 32'(raddr), mr % 16);
            rtick();
        end
        rd_req = 1'b0;
        check_val("underflow", 32'(underflow), 32'(ERR_EXP));

        // fill to full
        repeat (4) wtick();
        check_val("pre_fill_wlevel", 32'(wlevel), 0);
        wr_valid = 1'b1;
        for (int i = 0; i < 16; i++) begin
            wdata = 8'(mw);
            #1;
            check_val("fill_wenable", 32'(wenable), 1);
            check_val("fill_waddr", 32'(waddr), mw % 16);
            wtick();
            mw++;
            check_val("fill_wlevel", 32'(wlevel), i + 1);
            check_val("fill_afull", 32'(almost_full), (i + 1 >= 12) ? 1 : 0);
            check_val("fill_full", 32'(full), (i == 15) ? 1 : 0);
        end
        #1;
        check_val("full_wenable", 32'(wenable), 0);
        check_val("full_wr_ready", 32'(wr_ready), 0);
        wtick();
        wr_valid = 1'b0;
        check_val("full_waddr_hold", 32'(waddr), mw % 16);
        check_val("full_wlevel", 32'(wlevel), 16);
        check_val("overflow", 32'(overflow), 32'(ERR_EXP));
        repeat (4) rtick();
        check_val("full_rlevel", 32'(rlevel), 16);
        check_val("full_empty", 32'(empty), 0);
        check_val("full_aempty", 32'(almost_empty), 0);

        // read-to-space latency, wclk edge 8ns after rclk edge
        rd_req = 1'b1;
        #1;
        check_val("free_renable", 32'(renable), 1);
        rtick();
        rd_req = 1'b0;
        mr++;
        check_val("free_rdata", 32'(rdata), (mr - 1) & 32'hff);
        lat = 0;
        for (int k = 1; k <= 10; k++) begin
            wtick();
            if (!full) begin
                lat = k;
                break;
            end
        end
        check_val("full_fall_latency", lat, 3);
        check_val("free_wlevel", 32'(wlevel), 15);
        wr_valid = 1'b1;
        wdata    = 8'(mw);
        wtick();
        wr_valid = 1'b0;
        mw++;
        check_val("refill_full", 32'(full), 1);

        // drain at wclk:rclk = 1:3
        whalf = 5;
        rhalf = 15;
        repeat (2) rtick();
        rd_req = 1'b1;
        for (int i = 0; i < 16; i++) begin
            #1;
            check_val("drain_renable", 32'(renable), 1);
            check_val("drain_raddr", 32'(raddr), mr % 16);
            rtick();
            mr++;
            check_val("drain_dout_valid", 32'(dout_valid), 1);
            check_val("drain_rdata", 32'(rdata), (mr - 1) & 32'hff);
            check_val("drain_empty", 32'(empty), (i == 15) ? 1 : 0);
        end
        rd_req = 1'b0;
        rtick();
        check_val("drain_dout_idle", 32'(dout_valid), 0);
        check_val("drain_rlevel", 32'(rlevel), 0);
        check_val("drain_aempty", 32'(almost_empty), 1);
        repeat (4) wtick();
        check_val("drain_wfull", 32'(full), 0);
        check_val("drain_wlevel", 32'(wlevel), 0);

        // thresholds
        whalf = 5;
        rhalf = 5;
        repeat (3) rtick();
        repeat (3) wtick();
        wr_valid = 1'b1;
        for (int i = 0; i < 12; i++) begin
            wdata = 8'(mw);
            wtick();
            mw++;
            check_val("thr_wlevel", 32'(wlevel), i + 1);
            check_val("thr_afull", 32'(almost_full), (i == 11) ? 1 : 0);
        end
        wr_valid = 1'b0;
        repeat (5) rtick();
        check_val("thr_rlevel", 32'(rlevel), 12);
        check_val("thr_aempty_hi", 32'(almost_empty), 0);
        rd_req = 1'b1;
        for (int i = 0; i < 10; i++) begin
            rtick();
            mr++;
            check_val("thr_rlevel_dn", 32'(rlevel), 11 - i);
            check_val("thr_aempty", 32'(almost_empty), (i == 9) ? 1 : 0);
        end
        repeat (2) rtick();
        mr += 2;
        rd_req = 1'b0;
        check_val("thr_drained", 32'(empty), 1);

        // streaming with random stalls
        stream(7, 5, 48);
        stream(5, 7, 48);
        check_val("full_and_empty", both_viol, 0);

        // single-clock: write+read when empty, then fill, then write+read when full
        whalf = 5;
        repeat (2) wtick();
        s_wr_valid = 1'b1;
        s_rd_req   = 1'b1;
        #1;
        check_val("s_empty_wenable", 32'(s_wenable), 1);
        check_val("s_empty_renable", 32'(s_renable), 0);
        wtick();
        s_rd_req = 1'b0;
        check_val("s_empty_clear", 32'(s_empty), 0);
        check_val("s_rlevel1", 32'(s_rlevel), 1);
        check_val("s_raddr0", 32'(s_raddr), 0);
        check_val("s_waddr1", 32'(s_waddr), 1);
        repeat (15) wtick();
        check_val("s_full", 32'(s_full), 1);
        check_val("s_wlevel16", 32'(s_wlevel), 16);
        check_val("s_wr_ready", 32'(s_wr_ready), 0);
        s_rd_req = 1'b1;
        #1;
        check_val("s_full_wenable", 32'(s_wenable), 0);
        check_val("s_full_renable", 32'(s_renable), 1);
        wtick();
        s_wr_valid = 1'b0;
        s_rd_req   = 1'b0;
        check_val("s_full_clear", 32'(s_full), 0);
        check_val("s_wlevel15", 32'(s_wlevel), 15);
        check_val("s_waddr_hold", 32'(s_waddr), 0);
        check_val("s_raddr1", 32'(s_raddr), 1);
        check_val("s_dout_valid", 32'(s_dout_valid), 1);
        check_val("s_afull", 32'(s_almost_full), 1);
        check_val("s_overflow", 32'(s_overflow), 32'(ERR_EXP));

        // reset both domains with 9 words in flight
        wr_valid = 1'b1;
        for (int i = 0; i < 9; i++) begin
            wdata = 8'(mw);
            wtick();
            mw++;
        end
        wr_valid = 1'b0;
        wrstn = 1'b0;
        rrstn = 1'b0;
        #1;
        check_val("mid_rst_full", 32'(full), 0);
        check_val("mid_rst_wlevel", 32'(wlevel), 0);
        check_val("mid_rst_afull", 32'(almost_full), 0);
        check_val("mid_rst_empty", 32'(empty), 1);
        check_val("mid_rst_rlevel", 32'(rlevel), 0);
        check_val("mid_rst_aempty", 32'(almost_empty), 1);
        check_val("mid_rst_dout_valid", 32'(dout_valid), 0);
        check_val("mid_rst_waddr", 32'(waddr), 0);
        check_val("mid_rst_raddr", 32'(raddr), 0);
        check_val("mid_rst_underflow", 32'(underflow), 0);
        wtick();
        wrstn = 1'b1;
        rrstn = 1'b1;
        mw = 0;
        mr = 0;
        repeat (4) wtick();
        wr_valid = 1'b1;
        wdata    = 8'h5a;
        #1;
        check_val("post_rst_wenable", 32'(wenable), 1);
        check_val("post_rst_waddr", 32'(waddr), 0);
        wtick();
        wr_valid = 1'b0;
        lat = 0;
        for (int k = 1; k <= 10; k++) begin
            rtick();
            if (!empty) begin
                lat = k;
                break;
            end
        end
        check_val("post_rst_visible", 32'(lat != 0), 1);
        rd_req = 1'b1;
        #1;
        check_val("post_rst_raddr", 32'(raddr), 0);
        rtick();
        rd_req = 1'b0;
        check_val("post_rst_rdata", 32'(rdata), 32'h5a);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
